// File: rtl/vmem_burst.sv
// Single-clock word memory with single/burst reads and writes, a fixed read
// latency and a Busy/Valid/WAck handshake towards the CVP14 bus.
module vmem_burst #(
    parameter int DW   = 16,
    parameter int AW   = 16,
    parameter int LAT  = 2,
    parameter int BLEN = 16
) (
    input  logic          Clk1,
    input  logic          Reset_l,
    input  logic [AW-1:0] Addr,
    input  logic [DW-1:0] DataIn,
    input  logic          RD,
    input  logic          WR,
    input  logic          Burst,
    output logic [DW-1:0] DataOut,
    output logic          Valid,
    output logic          Busy,
    output logic          WAck,
    output logic          Err
);
    localparam int BW = (BLEN > 1) ? $clog2(BLEN) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BLEN - 1);

    typedef enum logic [1:0] {IDLE, RWAIT, RDATA, WBURST} state_t;

    state_t        state;
    logic [DW-1:0] mem [1 << AW];
    logic [AW-1:0] base;
    logic [BW-1:0] beat;
    logic [3:0]    cnt;
    logic          burst_q;

    logic          last_beat;
    logic          idle_like;
    logic          rd_req;
    logic          wr_req;
    logic          mem_we;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;

    // The edge that closes the final read beat also samples a new request.
    assign last_beat = !burst_q || (beat == LAST_BEAT);
    assign idle_like = (state == IDLE) || ((state == RDATA) && last_beat);
    assign rd_req    = idle_like && RD && !WR;
    assign wr_req    = idle_like && WR && !RD;
    assign mem_we    = Reset_l && (wr_req || (state == WBURST));

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        raddr = base + AW'(beat) + AW'(1);
        waddr = base + AW'(beat);
        if (rd_req) begin
            raddr = Addr;
        end else if (state == RWAIT) begin
            raddr = base;
        end
        if (wr_req) begin
            waddr = Addr;
        end
    end

    // NOTE: the array has no reset; contents survive Reset_l and start undefined.
    always_ff @(posedge Clk1) begin
        if (mem_we) begin
            mem[waddr] <= DataIn;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk1 or negedge Reset_l) begin
        if (!Reset_l) begin
            state   <= IDLE;
            DataOut <= '0;
            Valid   <= 1'b0;
            Busy    <= 1'b0;
            WAck    <= 1'b0;
            Err     <= 1'b0;
            cnt     <= '0;
            beat    <= '0;
            base    <= '0;
            burst_q <= 1'b0;
        end else begin
            Valid <= 1'b0;
            WAck  <= 1'b0;
            Err   <= 1'b0;
            if (idle_like) begin
                state <= IDLE;
                Busy  <= 1'b0;
                if (RD && WR) begin
                    Err <= 1'b1;
                end else if (rd_req) begin
                    base    <= Addr;
                    burst_q <= Burst;
                    beat    <= '0;
                    Busy    <= 1'b1;
                    if (LAT == 1) begin
                        DataOut <= mem[raddr];
                        Valid   <= 1'b1;
                        state   <= RDATA;
                    end else begin
                        cnt   <= 4'(LAT - 1);
                        state <= RWAIT;
                    end
                end else if (wr_req) begin
                    WAck <= 1'b1;
                    base <= Addr;
                    if (Burst) begin
                        beat  <= BW'(1);
                        Busy  <= 1'b1;
                        state <= WBURST;
                    end
                end
            end else begin
                case (state)
                    RWAIT: begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            DataOut <= mem[raddr];
                            Valid   <= 1'b1;
                            state   <= RDATA;
                        end
                    end
                    RDATA: begin
                        beat    <= beat + BW'(1);
                        DataOut <= mem[raddr];
                        Valid   <= 1'b1;
                    end
                    WBURST: begin
                        // Busy stays high through the final WAck cycle.
                        WAck <= 1'b1;
                        beat <= beat + BW'(1);
                        if (beat == LAST_BEAT) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/vmem_burst.md
# vmem_burst

Parametrised single-clock memory model with burst transfers and configurable read latency. It is the successor to the two-phase DRAM model that the CVP14 benches drive. It adds a busy/valid handshake, programmable data and address width, and fixed-length bursts matching vector register length, so one request moves a whole vector. It sits between the CVP14 bus (Addr/RD/WR/DataIn/DataOut) and the bench, and is also the memory-side endpoint for future vector load/store units.

## Interface
- DW, 16, data width in bits
- AW, 16, address width; depth is 2**AW words
- LAT, 2, read latency in cycles, legal range 1..15
- BLEN, 16, burst length in beats, power of two, 2..256
- Clk1  in  1  single clock, rising-edge active
- Reset_l  in  1  asynchronous, active-low reset
- Addr  in  AW  word address, sampled on the request edge
- DataIn  in  DW  write data, sampled on every write-beat edge
- RD  in  1  read request, sampled only in IDLE
- WR  in  1  write request, sampled only in IDLE
- Burst  in  1  with RD/WR, selects BLEN beats instead of 1
- DataOut  out  DW  read data, meaningful only while Valid=1
- Valid  out  1  DataOut holds a read beat
- Busy  out  1  transfer in progress; new requests ignored
- WAck  out  1  high the cycle after each accepted write beat
- Err  out  1  one-cycle pulse on an illegal request

## Operation
- The state machine has four states: IDLE, RWAIT, RDATA and WBURST.
- In IDLE, Busy=0 and a request is sampled on each rising edge:
  - RD=1, WR=0: latch base=Addr and the burst flag. If LAT=1 go to RDATA, otherwise go to RWAIT with the latency counter loaded to LAT-1.
  - WR=1, RD=0: write mem[Addr]<=DataIn on that edge (beat 0). If Burst=1, go to WBURST with beat=1; otherwise stay in IDLE.
  - RD=1, WR=1: no access. Pulse Err for one cycle and stay in IDLE.
- RWAIT decrements the counter each edge and moves to RDATA when the counter reaches 1.
- RDATA drives DataOut=mem[base+beat] with Valid=1:
  - Single read: one beat, then back to IDLE.
  - Burst read: BLEN consecutive beats (beat 0..BLEN-1), then back to IDLE.
- WBURST writes mem[base+beat]<=DataIn on each edge for beat 1..BLEN-1, then returns to IDLE. RD and WR are ignored during WBURST.
- Address arithmetic is base+beat, truncated to AW bits, so it wraps modulo 2**AW.
- Busy=1 in RWAIT, RDATA and WBURST. Requests arriving while Busy=1 are dropped, not queued.
- Reads are served from the array contents at the time each beat is launched. A read issued after a write burst completes always returns the new data.
- DataOut holds its last value when Valid=0.
- Memory contents are not cleared by reset. They are undefined until written; the bench may preload them with $readmemb.

## Timing
- Reset (Reset_l=0) forces, immediately and asynchronously: state=IDLE, DataOut=0, Valid=0, Busy=0, WAck=0, Err=0, counters=0.
- A reset asserted mid-transfer aborts it. Write beats completed on edges before the reset assertion remain in memory; no further beats are written. Operation resumes on the first rising edge after Reset_l returns to 1.
- Read latency: with the request sampled on edge N, Valid rises after edge N+LAT-1 and is first observed high in the cycle following that edge. Burst beats then follow on consecutive cycles with no gaps.
- Busy rises after the request edge. It falls after the edge that ends the last beat, so a new request can be sampled on the edge immediately after the final Valid or WAck cycle.
- Write: each beat's WAck is high for exactly the cycle following its write edge. A write burst asserts WAck for BLEN consecutive cycles.
- Err is high for exactly one cycle after the illegal edge. Busy stays 0.
- Total occupancy:
  - Read: LAT+BLEN-1 cycles for a burst, LAT for a single read.
  - Write: BLEN cycles for a burst, 0 for a single write (Busy never rises).

## Test plan
- Reset: hold Reset_l=0 with RD=1 toggling. Required: DataOut=0, Valid=0, Busy=0, WAck=0, Err=0 throughout; no state change.
- Single write/read (LAT=2): write 16'h1234 to 16'h0010, then read 16'h0010. Required: WAck high one cycle after the write; Valid high for exactly one cycle, appearing 2 cycles after the read edge, with DataOut=16'h1234.
- Burst write/read: write burst at 16'h0020 with data 16'hA000+i, i=0..15, then burst read. Required: 16 WAck cycles; then 16 gapless Valid cycles with DataOut 16'hA000..16'hA00F.
- Wrap-around: burst write then burst read at 16'hFFF8. Required: beats land at FFF8..FFFF then 0000..0007; read data is returned in the same order.
- Illegal and busy requests:
  - RD=WR=1 in IDLE: Err pulses one cycle; memory and Busy are unchanged.
  - RD pulsed during an active read burst: ignored, with no extra Valid cycles.
- Reset mid-burst: assert Reset_l=0 after 5 write beats of a burst at 16'h0040. Required: outputs clear immediately; a later read shows words 0x40..0x44 written and 0x45 unchanged; Busy=0.
